// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and flags.
// Define ALU_SEQ_MUL_EN to compile in the iterative shift-add multiplier (ctrl 101).
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       ctrl,
    input  logic             flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADDSUB = 3'b000,
        OP_LOGIC  = 3'b001,
        OP_SLT    = 3'b010,
        OP_SHIFT  = 3'b011,
        OP_SRA    = 3'b100,
        OP_MUL    = 3'b101,
        OP_ILL6   = 3'b110,
        OP_ILL7   = 3'b111
    } op_t;

    state_t state, state_next;

    op_t                op_q;
    logic               flag_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   b_x;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   a_next;
    logic [SHAMT_W-1:0] cnt_next;
    logic               finish;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;

    // Accumulator holds {partial product, remaining multiplier bits}; one bit retired per cycle.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        acc_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    if (finish) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        b_x = flag_q ? ~b_q : b_q;
        sum = {1'b0, a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, flag_q};

        if (op_q == OP_SRA) begin
            shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        end else if (flag_q) begin
            shifted = {a_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, a_q[WIDTH-1:1]};
        end

        finish   = 1'b1;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        a_next   = a_q;
        cnt_next = cnt_q;

        case (op_q)
            OP_ADDSUB: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_q[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_LOGIC: begin
                res = flag_q ? ~(a_q & b_q) : ~(a_q | b_q);
            end
            OP_SLT: begin
                res = flag_q ? WIDTH'($signed(a_q) < $signed(b_q)) : WIDTH'(a_q < b_q);
            end
            // The last shift step is folded into the finishing cycle, so a count of k costs k cycles.
            OP_SHIFT, OP_SRA: begin
                if (cnt_q != '0) begin
                    a_next   = shifted;
                    cnt_next = cnt_q - SHAMT_W'(1);
                end
                finish = (cnt_q <= SHAMT_W'(1));
                res    = (cnt_q == '0) ? a_q : shifted;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                cnt_next = cnt_q - SHAMT_W'(1);
                finish   = (cnt_q == '0);
                res      = acc_next[WIDTH-1:0];
                res_c    = |acc_next[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_ADDSUB;
            flag_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            out       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_t'(ctrl);
                        flag_q <= flag;
                        a_q    <= rs1;
                        b_q    <= rs2;
                        cnt_q  <= (op_t'(ctrl) == OP_MUL) ? SHAMT_W'(WIDTH - 1) : rs2[SHAMT_W-1:0];
`ifdef ALU_SEQ_MUL_EN
                        acc_q  <= {{WIDTH{1'b0}}, rs2};
`endif
                    end
                end
                EXEC: begin
                    a_q   <= a_next;
                    cnt_q <= cnt_next;
`ifdef ALU_SEQ_MUL_EN
                    acc_q <= acc_next;
`endif
                    if (finish) begin
                        out       <= res;
                        carry     <= res_c;
                        overflow  <= res_v;
                        zero      <= (res == '0);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expectations queued at accept, checked when out_valid rises.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic [2:0]   ctrl = '0;
    logic         flag = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         carry;
    logic         overflow;
    logic         zero;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .ctrl(ctrl), .flag(flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [7:0]  out;
        logic        c;
        logic        v;
        int unsigned lat;
        int unsigned acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   next_id  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] o, input logic c, input logic v, input int unsigned lat);
        exp_t e;
        e.id = 0; e.out = o; e.c = c; e.v = v; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    // Behavioural reference for randomised traffic.
    function automatic exp_t model(input logic [2:0] c, input logic f, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [8:0]  s;
        logic [15:0] p;
        int unsigned k;
        k = int'(b[2:0]);
        e = mk(8'h00, 1'b0, 1'b0, 1);
        case (c)
            3'd0: begin
                if (!f) begin
                    s = {1'b0, a} + {1'b0, b};
                    e.out = s[7:0];
                    e.c = s[8];
                    e.v = (a[7] == b[7]) && (s[7] != a[7]);
                end else begin
                    e.out = a - b;
                    e.c = (a >= b);
                    e.v = (a[7] != b[7]) && (e.out[7] != a[7]);
                end
            end
            3'd1: e.out = f ? ~(a & b) : ~(a | b);
            3'd2: e.out = f ? {7'b0, $signed(a) < $signed(b)} : {7'b0, a < b};
            3'd3: begin
                e.out = f ? (a << k) : (a >> k);
                e.lat = (k == 0) ? 1 : k;
            end
            3'd4: begin
                e.out = $signed(a) >>> k;
                e.lat = (k == 0) ? 1 : k;
            end
`ifdef ALU_SEQ_MUL_EN
            3'd5: begin
                p = a * b;
                e.out = p[7:0];
                e.c = |p[15:8];
                e.lat = 8;
            end
`endif
            default: ;
        endcase
        p = '0;
        return e;
    endfunction

    task automatic send(input logic [2:0] c, input logic f, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int unsigned w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", in_ready, 1'b1);
            return;
        end
        ctrl = c; flag = f; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.id = next_id++;
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        rs1 = 8'($urandom); rs2 = 8'($urandom); ctrl = 3'($urandom); flag = 1'($urandom);
    endtask

    task automatic drain(input string tag);
        int unsigned w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    logic seen = 1'b0;
    exp_t m;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                check_eq("unexpected_result", out_valid, 1'b0);
            end else begin
                m = sb.pop_front();
                check_eq($sformatf("op%0d_out", m.id), out, m.out);
                check_eq($sformatf("op%0d_carry", m.id), carry, m.c);
                check_eq($sformatf("op%0d_overflow", m.id), overflow, m.v);
                check_eq($sformatf("op%0d_zero", m.id), zero, m.out == 8'h00);
                check_eq($sformatf("op%0d_latency", m.id), cyc - m.acc_cyc, m.lat);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] rc;
        logic       rf;
        logic [7:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out", out, 8'h00);
        check_eq("rst_carry", carry, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_zero", zero, 1'b0);

        send(3'b000, 1'b0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1, 1));
        send(3'b000, 1'b1, 8'h05, 8'h05, mk(8'h00, 1'b1, 1'b0, 1));
        send(3'b000, 1'b1, 8'h03, 8'h05, mk(8'hFE, 1'b0, 1'b0, 1));
        send(3'b000, 1'b1, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1, 1));
        send(3'b000, 1'b0, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0, 1));
        send(3'b100, 1'b0, 8'h90, 8'h03, mk(8'hF2, 1'b0, 1'b0, 3));
        send(3'b011, 1'b0, 8'h90, 8'h03, mk(8'h12, 1'b0, 1'b0, 3));
        send(3'b011, 1'b1, 8'h01, 8'h07, mk(8'h80, 1'b0, 1'b0, 7));
        send(3'b011, 1'b1, 8'h5A, 8'h08, mk(8'h5A, 1'b0, 1'b0, 1));
        send(3'b100, 1'b1, 8'h81, 8'h07, mk(8'hFF, 1'b0, 1'b0, 7));
        send(3'b010, 1'b1, 8'h80, 8'h01, mk(8'h01, 1'b0, 1'b0, 1));
        send(3'b010, 1'b0, 8'h80, 8'h01, mk(8'h00, 1'b0, 1'b0, 1));
        send(3'b001, 1'b0, 8'hF0, 8'h3C, mk(8'h03, 1'b0, 1'b0, 1));
        send(3'b111, 1'b1, 8'hFF, 8'hFF, mk(8'h00, 1'b0, 1'b0, 1));
        send(3'b110, 1'b0, 8'h12, 8'h34, mk(8'h00, 1'b0, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
        send(3'b101, 1'b0, 8'h0F, 8'h11, mk(8'hFF, 1'b0, 1'b0, 8));
        send(3'b101, 1'b0, 8'h10, 8'h10, mk(8'h00, 1'b1, 1'b0, 8));
`else
        send(3'b101, 1'b0, 8'h0F, 8'h11, mk(8'h00, 1'b0, 1'b0, 1));
`endif
        drain("directed");

        // Back-pressure: result must hold while out_ready is low and no new op may slip in.
        out_ready = 1'b0;
        send(3'b001, 1'b1, 8'hF0, 8'h3C, mk(8'hCF, 1'b0, 1'b0, 1));
        begin
            int unsigned w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        check_eq("hold_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("hold%0d_out", i), out, 8'hCF);
            check_eq($sformatf("hold%0d_valid", i), out_valid, 1'b1);
            check_eq($sformatf("hold%0d_in_ready", i), in_ready, 1'b0);
            ctrl = 3'b000; flag = 1'b0; rs1 = 8'h01; rs2 = 8'h01; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_out_valid", out_valid, 1'b0);
        check_eq("release_in_ready", in_ready, 1'b1);
        drain("hold");

        send(3'b000, 1'b0, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, 1));
        drain("pre_rst");
        send(3'b011, 1'b1, 8'h01, 8'h07, mk(8'h80, 1'b0, 1'b0, 7));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_out", out, 8'h00);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        check_eq("midrst_zero", zero, 1'b0);
        sb.delete();
        rst = 1'b0;
        send(3'b000, 1'b0, 8'h02, 8'h03, mk(8'h05, 1'b0, 1'b0, 1));
        drain("post_rst");

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            rf = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(rc, rf, ra, rb, model(rc, rf, ra, rb));
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
